elapsed_timer_bcd: RTL and testbench

Count-up companion to the maze countdown timer. Measures the player's elapsed time as 4-digit BCD SS.hh (seconds.hundredths) from a 10 ms tick derived internally. Compares against a size-dependent limit, flags timeout, and keeps a best (lowest) completion time across games. Outputs feed the 7-segment display path directly; decimal point is on digit 2.

---
 rtl/elapsed_timer_bcd.sv | 141 ++++++++++++++
 tb/tb_elapsed_timer_bcd.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/elapsed_timer_bcd.sv
// Elapsed-time counter in BCD SS.hh with a size-dependent limit,
// timeout detection and a best-completion-time register.
module elapsed_timer_bcd #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        finish,
  input  logic [4:0]  size,
  output logic [15:0] elapsed,
  output logic [15:0] limit,
  output logic        running,
  output logic        paused,
  output logic        done,
  output logic        timeout,
  output logic [15:0] best,
  output logic        best_valid,
  output logic        new_best
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE,
    TIMEOUT
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic          tick;
  logic          go_done;
  logic          go_timeout;
  logic [15:0]   inc;

  function automatic logic [15:0] lim_of(input logic [4:0] s);
    logic [15:0] r;
    case (s)
      5'd5:    r = 16'h0300;
      5'd7:    r = 16'h0500;
      5'd9:    r = 16'h1000;
      5'd11:   r = 16'h1500;
      5'd13:   r = 16'h2000;
      5'd15:   r = 16'h2500;
      5'd17:   r = 16'h3000;
      default: r = 16'h3500;
    endcase
    return r;
  endfunction

  // Ripple BCD increment; 9999 is a fixed point so s10 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v != 16'h9999) begin
      if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
        else begin
          r[7:4] = 4'd0;
          if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
          else begin
            r[11:8]  = 4'd0;
            r[15:12] = r[15:12] + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  assign inc        = bcd_inc(elapsed);
  assign tick       = (state == RUN) && !pause && (presc == PMAX);
  assign go_done    = ((state == RUN) || (state == PAUSED)) && finish && !start;
  assign go_timeout = tick && !finish && !start && (inc == limit);

  assign running = (state == RUN);
  assign paused  = (state == PAUSED);
  assign done    = (state == DONE);
  assign timeout = (state == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) state_n = RUN;
    else begin
      case (state)
        RUN: begin
          if (finish)          state_n = DONE;
          else if (pause)      state_n = PAUSED;
          else if (go_timeout) state_n = TIMEOUT;
        end
        PAUSED: begin
          if (finish)      state_n = DONE;
          else if (!pause) state_n = RUN;
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed    <= 16'h0000;
      limit      <= 16'h0000;
      presc      <= '0;
      best       <= 16'h0000;
      best_valid <= 1'b0;
      new_best   <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (start) begin
        elapsed <= 16'h0000;
        limit   <= lim_of(size);
        presc   <= '0;
      end else begin
        if ((state == RUN) && !pause)
          presc <= tick ? '0 : presc + 1'b1;
        // finish on the tick edge freezes the pre-increment value
        if (tick && !finish)
          elapsed <= inc;
        if (go_done && (!best_valid || (elapsed < best))) begin
          best       <= elapsed;
          best_valid <= 1'b1;
          new_best   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_elapsed_timer_bcd.sv
// Directed bench for elapsed_timer_bcd with TICK_DIV=4
// (one BCD count every 4 cycles of RUN).
module tb_elapsed_timer_bcd;

  logic        clk = 1'b0;
  logic        rst, start, pause, finish;
  logic [4:0]  size;
  logic [15:0] elapsed, limit, best;
  logic        running, paused, done, timeout, best_valid, new_best;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elapsed_timer_bcd #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .finish(finish), .size(size), .elapsed(elapsed), .limit(limit),
    .running(running), .paused(paused), .done(done),
    .timeout(timeout), .best(best), .best_valid(best_valid),
    .new_best(new_best)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] s);
    size = s; start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1; cyc(1); finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
    checks++;
    if (elapsed !== 16'h0000 || limit !== 16'h0000 || best !== 16'h0000) begin
      failures++;
      $display("FAIL reset_regs elapsed=%h limit=%h best=%h req 0000", elapsed, limit, best);
    end
    checks++;
    if ({running, paused, done, timeout, best_valid, new_best} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b req=000000",
        {running, paused, done, timeout, best_valid, new_best});
    end
    do_finish();
    checks++;
    if (done !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL idle_finish done=%b running=%b req 0 0", done, running);
    end
  endtask

  task automatic test_count_and_best();
    do_start(5'd5);
    checks++;
    if (limit !== 16'h0300 || running !== 1'b1 || elapsed !== 16'h0000) begin
      failures++;
      $display("FAIL start limit=%h run=%b el=%h req 0300 1 0000", limit, running, elapsed);
    end
    cyc(3);
    checks++;
    if (elapsed !== 16'h0000) begin
      failures++; $display("FAIL pre_tick got=%h req=0000", elapsed);
    end
    cyc(1);
    checks++;
    if (elapsed !== 16'h0001) begin
      failures++; $display("FAIL first_tick got=%h req=0001", elapsed);
    end
    cyc(4 * 119);
    checks++;
    if (elapsed !== 16'h0120) begin
      failures++; $display("FAIL carry_120 got=%h req=0120", elapsed);
    end
    do_finish();
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || elapsed !== 16'h0120) begin
      failures++;
      $display("FAIL finish1 done=%b run=%b el=%h req 1 0 0120", done, running, elapsed);
    end
    checks++;
    if (best !== 16'h0120 || best_valid !== 1'b1 || new_best !== 1'b1) begin
      failures++;
      $display("FAIL best1 best=%h v=%b nb=%b req 0120 1 1", best, best_valid, new_best);
    end
    cyc(8);
    checks++;
    if (new_best !== 1'b0 || elapsed !== 16'h0120 || done !== 1'b1) begin
      failures++;
      $display("FAIL hold1 nb=%b el=%h done=%b req 0 0120 1", new_best, elapsed, done);
    end
    do_start(5'd5);
    cyc(4 * 150);
    do_finish();
    checks++;
    if (elapsed !== 16'h0150 || best !== 16'h0120 || new_best !== 1'b0) begin
      failures++;
      $display("FAIL slower el=%h best=%h nb=%b req 0150 0120 0", elapsed, best, new_best);
    end
    do_start(5'd5);
    cyc(4 * 90);
    do_finish();
    checks++;
    if (elapsed !== 16'h0090 || best !== 16'h0090 || new_best !== 1'b1) begin
      failures++;
      $display("FAIL faster el=%h best=%h nb=%b req 0090 0090 1", elapsed, best, new_best);
    end
    do_start(5'd5);
    cyc(4 * 90);
    do_finish();
    checks++;
    if (best !== 16'h0090 || new_best !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL tie best=%h nb=%b done=%b req 0090 0 1", best, new_best, done);
    end
  endtask

  task automatic test_timeout();
    do_start(5'd5);
    cyc(4 * 299);
    checks++;
    if (elapsed !== 16'h0299 || running !== 1'b1) begin
      failures++; $display("FAIL pre_limit el=%h run=%b req 0299 1", elapsed, running);
    end
    cyc(4);
    checks++;
    if (timeout !== 1'b1 || running !== 1'b0 || elapsed !== 16'h0300) begin
      failures++;
      $display("FAIL timeout to=%b run=%b el=%h req 1 0 0300", timeout, running, elapsed);
    end
    do_finish();
    cyc(200);
    checks++;
    if (timeout !== 1'b1 || done !== 1'b0 || elapsed !== 16'h0300 || best !== 16'h0090) begin
      failures++;
      $display("FAIL to_hold to=%b done=%b el=%h best=%h req 1 0 0300 0090",
        timeout, done, elapsed, best);
    end
  endtask

  task automatic test_pause();
    do_start(5'd9);
    size = 5'd5;
    cyc(4 * 10 + 2);
    checks++;
    if (elapsed !== 16'h0010 || limit !== 16'h1000) begin
      failures++; $display("FAIL pre_pause el=%h lim=%h req 0010 1000", elapsed, limit);
    end
    pause = 1'b1;
    cyc(20);
    checks++;
    if (paused !== 1'b1 || running !== 1'b0 || elapsed !== 16'h0010) begin
      failures++;
      $display("FAIL paused p=%b run=%b el=%h req 1 0 0010", paused, running, elapsed);
    end
    cyc(20);
    pause = 1'b0;
    cyc(1);
    checks++;
    if (running !== 1'b1 || elapsed !== 16'h0010) begin
      failures++; $display("FAIL resume run=%b el=%h req 1 0010", running, elapsed);
    end
    cyc(1);
    checks++;
    if (elapsed !== 16'h0010) begin
      failures++; $display("FAIL no_dup got=%h req=0010", elapsed);
    end
    cyc(1);
    checks++;
    if (elapsed !== 16'h0011) begin
      failures++; $display("FAIL no_loss got=%h req=0011", elapsed);
    end
  endtask

  task automatic test_same_cycle();
    do_start(5'd5);
    cyc(4 * 299 + 3);
    do_finish();
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || elapsed !== 16'h0299 || new_best !== 1'b0) begin
      failures++;
      $display("FAIL fin_on_limit done=%b to=%b el=%h nb=%b req 1 0 0299 0",
        done, timeout, elapsed, new_best);
    end
    do_start(5'd7);
    cyc(4 * 5);
    start = 1'b1; finish = 1'b1; size = 5'd17;
    cyc(1);
    start = 1'b0; finish = 1'b0;
    checks++;
    if (running !== 1'b1 || done !== 1'b0 || elapsed !== 16'h0000 || limit !== 16'h3000) begin
      failures++;
      $display("FAIL start_fin run=%b done=%b el=%h lim=%h req 1 0 0000 3000",
        running, done, elapsed, limit);
    end
    do_start(5'd4);
    checks++;
    if (limit !== 16'h3500) begin
      failures++; $display("FAIL lim_default got=%h req=3500", limit);
    end
    do_start(5'd13);
    checks++;
    if (limit !== 16'h2000) begin
      failures++; $display("FAIL lim_13 got=%h req=2000", limit);
    end
  endtask

  task automatic test_rst_mid_run();
    cyc(4 * 7);
    rst = 1'b1; cyc(1); rst = 1'b0;
    checks++;
    if ({running, paused, done, timeout, best_valid, new_best} !== 6'b0 ||
        elapsed !== 16'h0000 || limit !== 16'h0000 || best !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid flags=%b el=%h lim=%h best=%h req 000000 0000 0000 0000",
        {running, paused, done, timeout, best_valid, new_best}, elapsed, limit, best);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; finish = 1'b0; size = 5'd0;
    test_reset();
    test_count_and_best();
    test_timeout();
    test_pause();
    test_same_cycle();
    test_rst_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
